matc_result_streamer: RTL and testbench
=======================================

Name: matc_result_streamer

Overview:
Transmit end of the matrix-multiplier result path. Accepts one completed 2x2 result matrix C as a parallel word through a valid/ready handshake. Serialises C into a 6-byte framed stream (header, four sign-extended elements, XOR checksum) on a byte-wide valid/ready output, toward the pad-side readout or a bench monitor. Sits directly behind the multiplier core; paired with the operand loader on the input side.

Parameters:
EW, 2, operand element width (signed two's complement, range -2..1)
CW, 2*EW+1 = 5, result element width (signed; range -4..8 for EW=2)
HDR_TAG, 4'hA, upper nibble of the frame header byte

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, synchronous, active-low
ena  in  1  design enable; low = freeze
c_valid  in  1  result matrix present on c_data
c_ready  out  1  streamer can accept a result
c_data  in  4*CW  {C11,C10,C01,C00}; C00 in [CW-1:0]
tx_data  out  8  current stream byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  sink accepts byte
busy  out  1  frame in progress (state != IDLE)
seq  out  4  sequence number of the next/current frame

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, tx_valid=0, tx_data=8'h00, seq=0, element index=0, checksum=0, captured matrix cleared. Reset mid-frame drops the frame; no partial completion.
- c_ready = ena & (state==IDLE), combinational. Capture occurs when c_valid & c_ready at an edge.
- Output transfer occurs when tx_valid & tx_ready & ena at an edge. tx_data/tx_valid are registered and held stable until transfer.
- ena low: no capture, no transfer, no state, seq or checksum change; outputs hold their values.
- FSM:
  - IDLE: on capture, latch c_data, load tx_data={HDR_TAG,seq}, tx_valid=1, csum=header, go to HDR.
  - HDR: on transfer, present C00 sign-extended to 8 bits, csum^=byte, idx=0, go to ELEM.
  - ELEM: on transfer with idx<3, idx++, present next element (C01,C10,C11) and fold it into csum. On transfer with idx==3, present csum, go to CSUM.
  - CSUM: on transfer, tx_valid=0, seq=seq+1 (wraps 15->0), go to IDLE.
- Latency: header byte is valid the cycle after capture. A frame needs 6 transfers; minimum 7 cycles from capture to next c_ready. Back-to-back captures are never overlapped.
- Checksum = XOR of header and the four element bytes.
- Sign extension: byte = {{(8-CW){C[CW-1]}}, C}.
- c_valid while not ready is ignored; the source must hold it. c_data is not sampled outside capture.
- busy = (state != IDLE).

Decomposition:
- Shared package matmul_pkg: EW, CW, HDR_TAG, FRAME_LEN=6, state enum (IDLE,HDR,ELEM,CSUM), element-to-byte sign-extend function.
- No sub-module needed. A single FSM plus datapath fits in about 150-200 lines.

Test Plan:
- Basic frame: after reset, c_data=20'hE23C3 (C00=3, C01=-2, C10=8, C11=-4), tx_ready=1 -> bytes A0,03,FE,08,FC,A9 on consecutive cycles starting 1 cycle after capture; seq becomes 1.
- Second frame, all-zero C -> A1,00,00,00,00,A1; c_ready low for the 6 frame cycles, then high.
- Backpressure: tx_ready low for 3 cycles while the 03 byte is presented -> tx_data stays 03 and tx_valid stays 1; the rest of the frame is unchanged.
- ena low for 4 cycles mid-ELEM, with tx_ready=1 and c_valid=1 -> no progress, no capture; the stream resumes with the identical next byte.
- Seq wrap: 17 frames -> 16th header AF, 17th header A0.
- Reset during ELEM -> next cycle tx_valid=0, busy=0, seq=0, c_ready=ena; the next frame header is A0.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared constants, state encoding and helpers for the matrix-multiplier result path.
package matmul_pkg;

   localparam int unsigned EW        = 2;
   localparam int unsigned CW        = 2 * EW + 1;
   localparam logic [3:0]  HDR_TAG   = 4'hA;
   localparam int unsigned FRAME_LEN = 6;

   typedef enum logic [1:0] {
      StIdle,
      StHdr,
      StElem,
      StCsum
   } state_e;

   function automatic logic [7:0] sext_elem(input logic [CW-1:0] c);
      return {{(8 - CW){c[CW-1]}}, c};
   endfunction

endpackage

// File: rtl/matc_result_streamer.sv
// Serialises one 2x2 result matrix into a 6-byte frame: header, four elements, XOR checksum.
module matc_result_streamer
   import matmul_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            ena,
   input  logic            c_valid,
   output logic            c_ready,
   input  logic [4*CW-1:0] c_data,
   output logic [7:0]      tx_data,
   output logic            tx_valid,
   input  logic            tx_ready,
   output logic            busy,
   output logic [3:0]      seq
);

   state_e          state;
   logic [4*CW-1:0] mat;
   logic [1:0]      idx;
   logic [7:0]      csum;
   logic [7:0]      next_elem;
   logic [7:0]      first_elem;
   logic            xfer;

   assign c_ready    = ena & (state == StIdle);
   assign busy       = (state != StIdle);
   assign xfer       = tx_valid & tx_ready;
   assign first_elem = sext_elem(mat[CW-1:0]);

   // Element following the one currently presented at index idx.
   always_comb begin
      next_elem = 8'h00;
      unique case (idx)
         2'd0:    next_elem = sext_elem(mat[2*CW-1:CW]);
         2'd1:    next_elem = sext_elem(mat[3*CW-1:2*CW]);
         default: next_elem = sext_elem(mat[4*CW-1:3*CW]);
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= StIdle;
         mat      <= '0;
         idx      <= 2'd0;
         csum     <= 8'h00;
         tx_data  <= 8'h00;
         tx_valid <= 1'b0;
         seq      <= 4'd0;
      end else if (ena) begin
         unique case (state)
            StIdle: begin
               if (c_valid) begin
                  mat      <= c_data;
                  tx_data  <= {HDR_TAG, seq};
                  csum     <= {HDR_TAG, seq};
                  tx_valid <= 1'b1;
                  state    <= StHdr;
               end
            end
            StHdr: begin
               if (xfer) begin
                  tx_data <= first_elem;
                  csum    <= csum ^ first_elem;
                  idx     <= 2'd0;
                  state   <= StElem;
               end
            end
            StElem: begin
               if (xfer) begin
                  if (idx == 2'd3) begin
                     tx_data <= csum;
                     state   <= StCsum;
                  end else begin
                     idx     <= idx + 2'd1;
                     tx_data <= next_elem;
                     csum    <= csum ^ next_elem;
                  end
               end
            end
            StCsum: begin
               if (xfer) begin
                  tx_valid <= 1'b0;
                  seq      <= seq + 4'd1;
                  state    <= StIdle;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_matc_result_streamer.sv
// Directed self-checking bench for matc_result_streamer with hand-computed frames.
module tb_matc_result_streamer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic        c_valid;
   logic        c_ready;
   logic [19:0] c_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;
   logic [3:0]  seq;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   matc_result_streamer dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .c_valid  (c_valid),
      .c_ready  (c_ready),
      .c_data   (c_data),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .busy     (busy),
      .seq      (seq)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // exp packs the six frame bytes, first byte in [47:40].
   // stall_kind: 0 none, 1 tx_ready low, 2 ena low with c_valid high.
   task automatic run_frame(input logic [19:0] d, input logic [47:0] exp,
                            input int stall_idx, input int stall_kind, input int stall_len);
      logic [3:0] exp_seq;
      exp_seq = exp[43:40];
      check("seq_pre", {28'd0, seq}, {28'd0, exp_seq});
      check("c_ready_pre", {31'd0, c_ready}, 32'd1);
      c_data  = d;
      c_valid = 1'b1;
      step();
      c_valid = 1'b0;
      c_data  = '0;
      for (int k = 0; k < 6; k++) begin
         if (k == stall_idx && stall_kind != 0) begin
            if (stall_kind == 1) begin
               tx_ready = 1'b0;
            end else begin
               ena     = 1'b0;
               c_valid = 1'b1;
               c_data  = 20'hFFFFF;
            end
            for (int s = 0; s < stall_len; s++) begin
               step();
               check("stall_data", {24'd0, tx_data}, {24'd0, exp[47-8*k -: 8]});
               check("stall_valid", {31'd0, tx_valid}, 32'd1);
               check("stall_c_ready", {31'd0, c_ready}, 32'd0);
               check("stall_seq", {28'd0, seq}, {28'd0, exp_seq});
            end
            tx_ready = 1'b1;
            ena      = 1'b1;
            c_valid  = 1'b0;
            c_data   = '0;
         end
         check($sformatf("tx_data[%0d]", k), {24'd0, tx_data}, {24'd0, exp[47-8*k -: 8]});
         check("tx_valid", {31'd0, tx_valid}, 32'd1);
         check("busy", {31'd0, busy}, 32'd1);
         check("c_ready_busy", {31'd0, c_ready}, 32'd0);
         step();
      end
      check("tx_valid_end", {31'd0, tx_valid}, 32'd0);
      check("busy_end", {31'd0, busy}, 32'd0);
      check("c_ready_end", {31'd0, c_ready}, 32'd1);
      check("seq_post", {28'd0, seq}, {28'd0, exp_seq + 4'd1});
   endtask

   initial begin
      logic [7:0] hdr;
      rst_n    = 1'b0;
      ena      = 1'b1;
      c_valid  = 1'b0;
      c_data   = '0;
      tx_ready = 1'b1;
      step();
      step();
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_tx_data", {24'd0, tx_data}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_seq", {28'd0, seq}, 32'd0);
      check("rst_c_ready", {31'd0, c_ready}, 32'd1);
      rst_n = 1'b1;
      step();

      // C00=3, C01=-2, C10=8, C11=-4
      run_frame(20'hE23C3, 48'hA0_03_FE_08_FC_A9, -1, 0, 0);
      run_frame(20'h00000, 48'hA1_00_00_00_00_A1, -1, 0, 0);
      run_frame(20'hE23C3, 48'hA2_03_FE_08_FC_AB, 1, 1, 3);
      run_frame(20'hE23C3, 48'hA3_03_FE_08_FC_AA, 2, 2, 4);

      // Sequence wrap over 17 frames
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int f = 0; f < 17; f++) begin
         hdr = {4'hA, 4'(f % 16)};
         run_frame(20'h00000, {hdr, 32'h0, hdr}, -1, 0, 0);
      end

      // Reset mid-ELEM drops the frame
      c_data  = 20'hE23C3;
      c_valid = 1'b1;
      step();
      c_valid = 1'b0;
      step();
      step();
      check("mid_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      step();
      check("mrst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("mrst_busy", {31'd0, busy}, 32'd0);
      check("mrst_seq", {28'd0, seq}, 32'd0);
      check("mrst_c_ready", {31'd0, c_ready}, 32'd1);
      rst_n = 1'b1;
      run_frame(20'hE23C3, 48'hA0_03_FE_08_FC_A9, -1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
